// File: rtl/mask.sv
// Column-mask stage: zeroes every matrix column whose mask word is zero and
// registers the result with a one-cycle valid flag.
module mask #(
  parameter int N = 32,
  parameter int R = 6,
  parameter int C = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a [0:0][0:C-1],
  input  logic [N-1:0] b [0:R-1][0:C-1],
  output logic         out_valid,
  output logic [N-1:0] c [0:R-1][0:C-1]
);

  logic [C-1:0] w_keep;
  logic [N-1:0] w_masked [0:R-1][0:C-1];
  logic         r_valid;
  logic [N-1:0] r_c [0:R-1][0:C-1];

  // Any set bit keeps the column, so sign-magnitude negative zero keeps it too.
  always_comb begin
    w_keep = '0;
    for (int j = 0; j < C; j++) begin
      w_keep[j] = |a[0][j];
    end
  end

  always_comb begin
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        w_masked[i][j] = w_keep[j] ? b[i][j] : '0;
      end
    end
  end

  // Loading only under in_valid keeps idle-cycle X on a/b away from c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      for (int i = 0; i < R; i++) begin
        for (int j = 0; j < C; j++) begin
          r_c[i][j] <= '0;
        end
      end
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < R; i++) begin
          for (int j = 0; j < C; j++) begin
            r_c[i][j] <= w_masked[i][j];
          end
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign c         = r_c;

endmodule

// File: tb/tb_mask.sv
// Scoreboard bench for mask: expected matrices are queued when a valid
// input is driven and popped when the registered result appears.
module tb_mask;

  localparam int N = 32;
  localparam int R = 6;
  localparam int C = 6;

  typedef logic [R*C*N-1:0] flat_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] a [0:0][0:C-1];
  logic [N-1:0] b [0:R-1][0:C-1];
  logic         out_valid;
  logic [N-1:0] c [0:R-1][0:C-1];

  int    vectors;
  int    miscompares;
  flat_t expQ[$];
  flat_t got;
  flat_t exp;
  flat_t held;

  mask #(.N(N), .R(R), .C(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .c         (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a column survives when its mask word has any bit set.
  function automatic flat_t modelOut();
    flat_t e;
    e = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        e[(i*C+j)*N +: N] = (a[0][j] != '0) ? b[i][j] : '0;
    return e;
  endfunction

  function automatic flat_t flatC();
    flat_t f;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        f[(i*C+j)*N +: N] = c[i][j];
    return f;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomB();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        b[i][j] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    for (int j = 0; j < C; j++) a[0][j] = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) b[i][j] = '0;
    #2;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    vectors++;
    got = flatC();
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_c: got %h expected 0", got);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mixed();
    a[0][0] = 32'h00ffffff;
    a[0][1] = 32'h00000000;
    for (int j = 2; j < C; j++) a[0][j] = 32'h00056fc2;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) b[i][j] = 32'h0006487e;
    in_valid = 1'b1;
    expQ.push_back(modelOut());
    cycle();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mixed_valid: got %b expected 1", out_valid);
    end
    vectors++;
    got = flatC();
    exp = expQ.pop_front();
    if (got !== exp) begin
      miscompares++;
      $display("FAIL mixed_c: got %h expected %h", got, exp);
    end
    vectors++;
    if (c[3][1] !== 32'h0 || c[5][2] !== 32'h0006487e) begin
      miscompares++;
      $display("FAIL mixed_cols: got %h/%h expected 00000000/0006487e", c[3][1], c[5][2]);
    end
  endtask

  task automatic test_zero_ones();
    for (int j = 0; j < C; j++) a[0][j] = '0;
    randomB();
    in_valid = 1'b1;
    expQ.push_back(modelOut());
    cycle();
    vectors++;
    got = flatC();
    exp = expQ.pop_front();
    if (out_valid !== 1'b1 || got !== exp || got !== '0) begin
      miscompares++;
      $display("FAIL zero_mask: got v=%b %h expected v=1 %h", out_valid, got, exp);
    end
    for (int j = 0; j < C; j++) a[0][j] = 32'hffffffff;
    randomB();
    expQ.push_back(modelOut());
    cycle();
    in_valid = 1'b0;
    vectors++;
    got = flatC();
    exp = expQ.pop_front();
    if (out_valid !== 1'b1 || got !== exp) begin
      miscompares++;
      $display("FAIL ones_mask: got v=%b %h expected v=1 %h", out_valid, got, exp);
    end
  endtask

  task automatic test_hold();
    for (int j = 0; j < C; j++) a[0][j] = 32'h1;
    randomB();
    in_valid = 1'b1;
    expQ.push_back(modelOut());
    cycle();
    held = expQ.pop_front();
    vectors++;
    got = flatC();
    if (got !== held) begin
      miscompares++;
      $display("FAIL hold_load: got %h expected %h", got, held);
    end
    in_valid = 1'b0;
    for (int j = 0; j < C; j++) a[0][j] = 'x;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) b[i][j] = 'x;
    cycle();
    cycle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_valid: got %b expected 0", out_valid);
    end
    vectors++;
    got = flatC();
    if (got !== held) begin
      miscompares++;
      $display("FAIL hold_c: got %h expected %h", got, held);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < C; j++)
        a[0][j] = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
      randomB();
      in_valid = 1'b1;
      expQ.push_back(modelOut());
      cycle();
      vectors++;
      if (out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_valid%0d: got %b expected 1", k, out_valid);
      end
      vectors++;
      got = flatC();
      exp = expQ.pop_front();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL stream_c%0d: got %h expected %h", k, got, exp);
      end
    end
    in_valid = 1'b0;
    cycle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_end: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_edge_masks();
    a[0][0] = 32'h80000000;
    a[0][1] = 32'h00000001;
    a[0][2] = 32'h00000000;
    a[0][3] = 32'h80000000;
    a[0][4] = 32'h00000000;
    a[0][5] = 32'h00000001;
    randomB();
    b[2][0] = 32'h12345678;
    b[4][1] = 32'h9abcdef0;
    in_valid = 1'b1;
    expQ.push_back(modelOut());
    cycle();
    in_valid = 1'b0;
    vectors++;
    got = flatC();
    exp = expQ.pop_front();
    if (out_valid !== 1'b1 || got !== exp) begin
      miscompares++;
      $display("FAIL edge_c: got v=%b %h expected v=1 %h", out_valid, got, exp);
    end
    vectors++;
    if (c[2][0] !== 32'h12345678 || c[4][1] !== 32'h9abcdef0 || c[0][2] !== 32'h0) begin
      miscompares++;
      $display("FAIL edge_cols: got %h/%h/%h expected 12345678/9abcdef0/00000000",
               c[2][0], c[4][1], c[0][2]);
    end
  endtask

  task automatic test_reset_midrun();
    for (int j = 0; j < C; j++) a[0][j] = 32'hffffffff;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) b[i][j] = 32'h00abcdef;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    got = flatC();
    if (out_valid !== 1'b0 || got !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got v=%b %h expected v=0 0", out_valid, got);
    end
    cycle();
    vectors++;
    got = flatC();
    if (out_valid !== 1'b0 || got !== '0) begin
      miscompares++;
      $display("FAIL reset_held: got v=%b %h expected v=0 0", out_valid, got);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mixed();
    test_zero_ones();
    test_hold();
    test_back_to_back();
    test_edge_masks();
    test_reset_midrun();
    test_mixed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
